// File: rtl/host_link_pkg.sv
// Shared definitions for the host link command/result stage.
// State encodings, data widths and the timeout result sentinel.
package stack_defs;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RX_LO = 3'd1;
  localparam logic [2:0] ST_GO    = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_TX_HI = 3'd4;
  localparam logic [2:0] ST_TX_LO = 3'd5;

  localparam logic [DATA_W-1:0] TIMEOUT_SENTINEL = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    RX_LO = ST_RX_LO,
    GO    = ST_GO,
    RUN   = ST_RUN,
    TX_HI = ST_TX_HI,
    TX_LO = ST_TX_LO
  } state_e;

  function automatic logic [BYTE_W-1:0] sat_inc(
    input logic [BYTE_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/host_link_timer.sv
// Run-length counter with terminal-count flag for the host link.
// Clear wins over enable; flag compares the current count.
module host_link_timer #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic clk,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [TIMEOUT_W-1:0] cnt_q;
  logic [TIMEOUT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/host_link.sv
// Host-side command/result stage: two rx bytes form an operand,
// the core is started, and its answer goes back as two tx bytes.
module host_link
  import stack_defs::*;
#(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int TIMEOUT_W      = 17
) (
  input  logic              clk,
  input  logic              async_reset,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [DATA_W-1:0] user_input,
  output logic              go,
  input  logic              done,
  input  logic [DATA_W-1:0] answer,
  output logic              busy,
  output logic              timeout,
  output logic [BYTE_W-1:0] drop_count
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   ui_q, ui_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic                to_q, to_d;
  logic [BYTE_W-1:0]   drop_q, drop_d;
  logic                tmr_clr;
  logic                tmr_en;
  logic                tmr_tc;

  host_link_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_W     (TIMEOUT_W)
  ) u_timer (
    .clk  (clk),
    .rst_i(async_reset),
    .clr_i(tmr_clr),
    .en_i (tmr_en),
    .tc_o (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    ui_d    = ui_q;
    res_d   = res_q;
    to_d    = to_q;
    drop_d  = drop_q;
    tmr_clr = 1'b0;
    tmr_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_valid) begin
          ui_d[15:8] = rx_data;
          state_d    = RX_LO;
        end
      end
      RX_LO: begin
        if (rx_valid) begin
          ui_d[7:0] = rx_data;
          state_d   = GO;
        end
      end
      GO: begin
        to_d    = 1'b0;
        tmr_clr = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        tmr_en = 1'b1;
        if (done) begin
          res_d   = answer;
          state_d = TX_HI;
        end else if (tmr_tc) begin
          res_d   = TIMEOUT_SENTINEL;
          to_d    = 1'b1;
          state_d = TX_HI;
        end
      end
      TX_HI: begin
        if (tx_ready) begin
          state_d = TX_LO;
        end
      end
      TX_LO: begin
        if (tx_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Bytes are only consumed while assembling an operand
    if (rx_valid && state_q != IDLE && state_q != RX_LO) begin
      drop_d = sat_inc(drop_q);
    end
  end

  always_ff @(posedge clk) begin
    if (async_reset) begin
      state_q <= IDLE;
      ui_q    <= '0;
      res_q   <= '0;
      to_q    <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ui_q    <= ui_d;
      res_q   <= res_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    tx_data = '0;
    if (state_q == TX_HI) begin
      tx_data = res_q[15:8];
    end else if (state_q == TX_LO) begin
      tx_data = res_q[7:0];
    end
  end

  assign tx_valid   = (state_q == TX_HI) || (state_q == TX_LO);
  assign go         = (state_q == GO);
  assign busy       = (state_q != IDLE);
  assign user_input = ui_q;
  assign timeout    = to_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_host_link.sv
// Scoreboard bench for host_link: random commands against a
// cycle-count reference model, tx bytes checked by a monitor.
module tb_host_link;

  localparam int TO = 12;
  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        async_reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [15:0] user_input;
  logic        go;
  logic        done;
  logic [15:0] answer;
  logic        busy;
  logic        timeout;
  logic [7:0]  drop_count;

  int checks = 0;
  int failures = 0;
  int go_seen = 0;
  int go_exp = 0;
  int drops_model = 0;
  bit rdy_rand = 1'b0;
  logic [7:0] exp_q[$];
  logic       hold_q = 1'b0;
  logic [7:0] hold_data_q = '0;

  always #5 clk = ~clk;

  host_link #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_W     (TW)
  ) dut (
    .clk        (clk),
    .async_reset(async_reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .user_input (user_input),
    .go         (go),
    .done       (done),
    .answer     (answer),
    .busy       (busy),
    .timeout    (timeout),
    .drop_count (drop_count)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) tx_ready = ($urandom_range(0, 3) != 0);
  endtask

  function automatic void model_drop();
    if (drops_model < 255) drops_model++;
  endfunction

  // Monitor: pops an expected byte on every tx handshake
  always @(negedge clk) begin
    if (async_reset) begin
      hold_q <= 1'b0;
    end else begin
      if (hold_q && tx_valid) chk("tx_stable", tx_data, hold_data_q);
      if (go) go_seen <= go_seen + 1;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL tx_unexpected got=%0h want=none", tx_data);
        end else begin
          chk("tx_byte", tx_data, exp_q.pop_front());
        end
      end
      hold_q      <= tx_valid && !tx_ready;
      hold_data_q <= tx_data;
    end
  end

  // Sends a command; returns positioned in the cycle after done
  task automatic issue_cmd(input logic [15:0] op, input int d,
                           input logic [15:0] ans, input bit drops);
    logic [15:0] exp_res;
    bit          exp_to;
    rx_data  = op[15:8];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    repeat ($urandom_range(0, 3)) tick();
    rx_data  = op[7:0];
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    chk("go_pulse", go, 1'b1);
    chk("go_operand", user_input, op);
    chk("go_busy", busy, 1'b1);
    go_exp++;
    exp_to  = !(d >= 1 && d <= TO);
    exp_res = exp_to ? 16'hFFFF : ans;
    exp_q.push_back(exp_res[15:8]);
    exp_q.push_back(exp_res[7:0]);
    answer = ans;
    done   = (d == 0);
    for (int k = 1; k <= d; k++) begin
      tick();
      if (k == 1) chk("to_cleared", timeout, 1'b0);
      done     = (k == d);
      rx_data  = 8'($urandom);
      rx_valid = drops && k <= TO && ($urandom_range(0, 2) == 0);
      if (rx_valid) model_drop();
    end
    tick();
    done     = 1'b0;
    rx_valid = 1'b0;
    answer   = 16'($urandom);
  endtask

  task automatic finish_cmd(input logic [15:0] op, input int d);
    int n = 0;
    while (busy && n < 300) begin
      tick();
      n++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("FAIL idle_wait got=busy want=idle");
    end
    chk("timeout_flag", timeout, !(d >= 1 && d <= TO));
    chk("drop_count", drop_count, drops_model);
    chk("operand_hold", user_input, op);
  endtask

  task automatic run_cmd(input logic [15:0] op, input int d,
                         input logic [15:0] ans, input bit drops);
    issue_cmd(op, d, ans, drops);
    finish_cmd(op, d);
  endtask

  initial begin
    int n;
    async_reset = 1'b1;
    rx_data     = '0;
    rx_valid    = 1'b0;
    tx_ready    = 1'b0;
    done        = 1'b0;
    answer      = '0;
    repeat (3) tick();
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_operand", user_input, 16'h0);
    chk("rst_go", go, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_drops", drop_count, 8'h0);
    async_reset = 1'b0;
    rdy_rand    = 1'b1;
    tick();

    run_cmd(16'h002A, 10, 16'h000B, 1'b0);

    // Stall in TX_HI with a flood of dropped bytes, then reset in TX_LO
    rdy_rand = 1'b0;
    tx_ready = 1'b0;
    issue_cmd(16'h1234, 3, 16'hBEEF, 1'b0);
    repeat (5) begin
      chk("stall_valid", tx_valid, 1'b1);
      chk("stall_data", tx_data, 8'hBE);
      tick();
    end
    for (int i = 0; i < 300; i++) begin
      rx_data  = 8'($urandom);
      rx_valid = 1'b1;
      model_drop();
      tick();
    end
    rx_valid = 1'b0;
    chk("drop_sat", drop_count, 8'd255);
    chk("stall_data2", tx_data, 8'hBE);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("txlo_data", tx_data, 8'hEF);
    async_reset = 1'b1;
    tick();
    async_reset = 1'b0;
    exp_q.delete();
    drops_model = 0;
    chk("rst2_tx_valid", tx_valid, 1'b0);
    chk("rst2_busy", busy, 1'b0);
    chk("rst2_operand", user_input, 16'h0);
    chk("rst2_drops", drop_count, 8'h0);

    // Byte arriving as TX_LO completes is still dropped
    issue_cmd(16'h0102, 2, 16'h5A5A, 1'b0);
    tx_ready = 1'b1;
    tick();
    rx_data  = 8'h77;
    rx_valid = 1'b1;
    model_drop();
    tick();
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    chk("txlo_done_idle", busy, 1'b0);
    chk("txlo_drop", drop_count, drops_model);
    rdy_rand = 1'b1;

    run_cmd(16'h00FF, 20, 16'h1111, 1'b0);
    run_cmd(16'hA5C3, TO, 16'h4321, 1'b1);
    run_cmd(16'h5A3C, TO + 1, 16'h8765, 1'b1);
    run_cmd(16'hFFFF, 0, 16'h0F0F, 1'b0);
    run_cmd(16'h8001, 1, 16'hF00D, 1'b1);
    for (int i = 0; i < 20; i++) begin
      run_cmd(16'($urandom), $urandom_range(0, TO + 3),
              16'($urandom), 1'b1);
    end

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("queue_empty", exp_q.size(), 0);
    tick();
    chk("go_count", go_seen, go_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/host_link.md
Name: host_link

Overview:
- Host-side command/result stage for the stack processor.
- Upstream: assembles a 16-bit operand from a byte-serial receive stream, drives it onto the core's user input and pulses go.
- Downstream: waits for the core's done, captures the 16-bit answer and returns it as two transmit bytes.
- Sits between the byte-level UART and the processor top level.

Parameters:
- TIMEOUT_CYCLES, 100000: max cycles in RUN before the run is aborted.
- TIMEOUT_W, 17: counter width; must satisfy 2^TIMEOUT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- async_reset  in  1  reset, synchronous to clk, active-high (port name kept for codebase consistency).
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data valid this cycle.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- user_input  out  16  operand to core; stable from GO through end of RUN.
- go  out  1  one-cycle start pulse to core.
- done  in  1  core completion (level or pulse; sampled only in RUN).
- answer  in  16  core result; sampled in the cycle done is seen.
- busy  out  1  high in every state except IDLE.
- timeout  out  1  sticky; last run aborted. Cleared on next GO.
- drop_count  out  8  saturating count of rx bytes discarded.

Behaviour:
- Reset (async_reset=1 at a clk edge):
  - state=IDLE; user_input=0; go=0; tx_valid=0; tx_data=0.
  - Result latch=0; timeout=0; drop_count=0; run counter=0.
  - Reset has priority over every other event, including an in-flight TX handshake; a pending byte is abandoned.
- States: IDLE, RX_LO, GO, RUN, TX_HI, TX_LO.
- IDLE: on rx_valid, latch rx_data into user_input[15:8] -> RX_LO.
- RX_LO: on rx_valid, latch rx_data into user_input[7:0] -> GO.
  - No inter-byte timeout; the low byte may arrive any number of cycles later.
- GO:
  - go=1 for exactly this cycle; clear timeout; clear run counter -> RUN.
  - First operand to go latency: go rises the cycle after the second rx_valid.
- RUN: each cycle, increment run counter.
  - done=1: result latch=answer -> TX_HI. done in the GO cycle is ignored.
  - Else if counter == TIMEOUT_CYCLES-1: result latch=16'hFFFF, timeout=1 -> TX_HI.
  - done and timeout in the same cycle: done wins, timeout stays 0.
- TX_HI: tx_valid=1, tx_data=result[15:8]; on tx_ready -> TX_LO.
- TX_LO: tx_valid=1, tx_data=result[7:0]; on tx_ready: tx_valid=0 -> IDLE.
  - tx_data must not change while tx_valid=1 and tx_ready=0.
- Byte order: big-endian on both rx and tx.
- rx_valid outside IDLE/RX_LO:
  - Byte discarded; drop_count+1, saturating at 255; no state change.
  - A byte arriving in the same cycle TX_LO completes is still dropped.
- go is never asserted outside GO. busy = (state != IDLE).

Decomposition:
- Shared package (stack_defs):
  - state encodings (3-bit localparams);
  - TIMEOUT_SENTINEL = 16'hFFFF;
  - DATA_W = 16, BYTE_W = 8.
- Optional sub-module host_link_timer: run counter plus terminal-count compare, with clear/enable inputs. Everything else stays flat in one FSM module.

Test Plan:
- Reset, then bytes 0x00, 0x2A (rx_valid 1 cycle each) -> user_input=0x002A, go pulses once the cycle after the 2nd byte, busy=1.
- After go, answer=0x000B, done=1 ten cycles later, tx_ready=1 -> tx bytes 0x00 then 0x0B, back to IDLE, busy=0, timeout=0.
- tx_ready held 0 for 5 cycles in TX_HI -> tx_valid stays 1 and tx_data stays 0x00 throughout; proceeds on tx_ready=1.
- TIMEOUT_CYCLES=8, done never asserted -> after 8 RUN cycles tx bytes 0xFF, 0xFF, timeout=1; next command clears timeout at GO.
- 3 rx_valid strobes during RUN -> drop_count=3, user_input unchanged, result unaffected; 300 drops -> drop_count=255.
- async_reset asserted in TX_LO with tx_ready=0 -> next cycle state IDLE, tx_valid=0, user_input=0, drop_count=0; new command runs normally.
